// File: rtl/meter_pkg.sv
// Shared constants for the meter countdown: add amounts, presets and BCD helper.
// Used by meter_bcd_timer (optional blink generation is enabled with METER_BLINK_EN).
package meter_pkg;

  typedef enum logic [1:0] {
    ADD_10  = 2'd0,
    ADD_180 = 2'd1,
    ADD_200 = 2'd2,
    ADD_550 = 2'd3
  } add_code_e;

  localparam logic [15:0] AMT_10_BCD  = 16'h0010;
  localparam logic [15:0] AMT_180_BCD = 16'h0180;
  localparam logic [15:0] AMT_200_BCD = 16'h0200;
  localparam logic [15:0] AMT_550_BCD = 16'h0550;

  localparam logic [15:0] PRESET_10_BCD  = 16'h0010;
  localparam logic [15:0] PRESET_205_BCD = 16'h0205;

  function automatic logic [15:0] add_amount(input logic [1:0] sel);
    logic [15:0] amt;
    amt = AMT_10_BCD;
    case (add_code_e'(sel))
      ADD_10:  amt = AMT_10_BCD;
      ADD_180: amt = AMT_180_BCD;
      ADD_200: amt = AMT_200_BCD;
      ADD_550: amt = AMT_550_BCD;
      default: amt = AMT_10_BCD;
    endcase
    return amt;
  endfunction

  // Elaboration-time conversion of integer parameters to packed BCD.
  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned rest;
    r = '0;
    rest = v;
    for (int unsigned i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/meter_bcd_timer_bcd_digit.sv
// One BCD digit slice: decimal add with carry chain and decrement with borrow chain.
// Part of meter_bcd_timer (see METER_BLINK_EN in the top file).
module bcd_digit (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] raw;

  // raw - 10 modulo 16 equals raw[3:0] + 6, avoiding a 5-bit subtract.
  always_comb begin
    raw  = {1'b0, digit} + {1'b0, addend} + {4'b0, cin};
    cout = (raw > 5'd9);
    sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
  end

  always_comb begin
    bout = bin & (digit == 4'd0);
    if (!bin)
      diff = digit;
    else if (digit == 4'd0)
      diff = 4'd9;
    else
      diff = digit - 4'd1;
  end

endmodule

// File: rtl/meter_bcd_timer.sv
// Parking-meter style BCD countdown with add/preset requests and saturation.
// Define METER_BLINK_EN to generate the blank blink phase; otherwise blank is 0.
module meter_bcd_timer
  import meter_pkg::*;
#(
  parameter int unsigned SAT_MAX    = 9999,
  parameter int unsigned LOW_THRESH = 200
) (
  input  logic        second_clk,
  input  logic        reset,
  input  logic        add_valid,
  input  logic [1:0]  add_sel,
  output logic        add_ready,
  input  logic        load_valid,
  input  logic        load_sel,
  output logic [15:0] bcd,
  output logic        expired,
  output logic        low_time,
  output logic        blank
);

  localparam logic [15:0] SAT_BCD = to_bcd(SAT_MAX);
  localparam logic [15:0] LOW_BCD = to_bcd(LOW_THRESH);

  logic [15:0] amount;
  logic [15:0] sum_bcd;
  logic [15:0] dec_bcd;
  logic [15:0] next_bcd;
  logic [4:0]  carry;
  logic [4:0]  borrow;
  logic        saturate;

  assign amount    = add_amount(add_sel);
  assign carry[0]  = 1'b0;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .digit  (bcd[4*i +: 4]),
      .addend (amount[4*i +: 4]),
      .cin    (carry[i]),
      .sum    (sum_bcd[4*i +: 4]),
      .cout   (carry[i+1]),
      .bin    (borrow[i]),
      .diff   (dec_bcd[4*i +: 4]),
      .bout   (borrow[i+1])
    );
  end

  // Packed BCD orders the same as its decimal value, so a plain compare works.
  assign saturate  = carry[4] | (sum_bcd > SAT_BCD);
  assign add_ready = add_valid & ~load_valid & ~reset;
  assign expired   = (bcd == '0);
  assign low_time  = ~expired & (bcd < LOW_BCD);

  // A borrow out of the top digit means the count is already 0000: hold.
  always_comb begin
    next_bcd = bcd;
    if (load_valid)
      next_bcd = load_sel ? PRESET_205_BCD : PRESET_10_BCD;
    else if (add_valid)
      next_bcd = saturate ? SAT_BCD : sum_bcd;
    else if (!borrow[4])
      next_bcd = dec_bcd;
  end

  always_ff @(posedge second_clk) begin
    if (reset)
      bcd <= '0;
    else
      bcd <= next_bcd;
  end

`ifdef METER_BLINK_EN
  logic blank_q;
  logic next_expired;
  logic next_low;

  assign next_expired = (next_bcd == '0);
  assign next_low     = ~next_expired & (next_bcd < LOW_BCD);

  // Registered against the next count so blank lines up with bcd; a fresh
  // entry into the low window always starts the blink at 0.
  always_ff @(posedge second_clk) begin
    if (reset)
      blank_q <= 1'b0;
    else if (next_expired)
      blank_q <= 1'b1;
    else if (next_low)
      blank_q <= low_time ? ~blank_q : 1'b0;
    else
      blank_q <= 1'b0;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_meter_bcd_timer.sv
// Scoreboard bench for meter_bcd_timer: driver pushes model expectations, monitor checks.
// Honours METER_BLINK_EN the same way the design does.
module tb_meter_bcd_timer;

  localparam int unsigned SAT_MAX    = 9999;
  localparam int unsigned LOW_THRESH = 200;

`ifdef METER_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        second_clk;
  logic        reset;
  logic        add_valid;
  logic [1:0]  add_sel;
  logic        add_ready;
  logic        load_valid;
  logic        load_sel;
  logic [15:0] bcd;
  logic        expired;
  logic        low_time;
  logic        blank;

  meter_bcd_timer #(
    .SAT_MAX    (SAT_MAX),
    .LOW_THRESH (LOW_THRESH)
  ) dut (
    .second_clk (second_clk),
    .reset      (reset),
    .add_valid  (add_valid),
    .add_sel    (add_sel),
    .add_ready  (add_ready),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .bcd        (bcd),
    .expired    (expired),
    .low_time   (low_time),
    .blank      (blank)
  );

  initial second_clk = 1'b0;
  always #5 second_clk = ~second_clk;

  typedef struct {
    int unsigned cyc;
    logic        ready;
    logic [15:0] bcd;
    logic        expired;
    logic        low;
    logic        blank;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining seconds as a plain integer.
  int unsigned rem     = 0;
  int unsigned low_run = 0;
  bit          blank_m = 1'b0;
  int unsigned cyc_n   = 0;

  function automatic logic [15:0] dec_to_bcd(input int unsigned v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int unsigned amount_of(input logic [1:0] sel);
    int unsigned a;
    case (sel)
      2'd0: a = 10;
      2'd1: a = 180;
      2'd2: a = 200;
      default: a = 550;
    endcase
    return a;
  endfunction

  task automatic step(input bit r, input bit lv, input bit ls, input bit av, input logic [1:0] as);
    exp_t e;
    @(negedge second_clk);
    reset = r; load_valid = lv; load_sel = ls; add_valid = av; add_sel = as;
    e.ready = av && !lv && !r;
    if (r) begin
      rem = 0; blank_m = 1'b0; low_run = 0;
    end else begin
      if (lv)
        rem = ls ? 205 : 10;
      else if (av)
        rem = (rem + amount_of(as) > SAT_MAX) ? SAT_MAX : rem + amount_of(as);
      else if (rem > 0)
        rem = rem - 1;
      if (rem == 0) begin
        blank_m = 1'b1; low_run = 0;
      end else if (rem < LOW_THRESH) begin
        blank_m = low_run[0]; low_run++;
      end else begin
        blank_m = 1'b0; low_run = 0;
      end
    end
    cyc_n++;
    e.cyc     = cyc_n;
    e.bcd     = dec_to_bcd(rem);
    e.expired = (rem == 0);
    e.low     = (rem > 0) && (rem < LOW_THRESH);
    e.blank   = BLINK_EN ? blank_m : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Monitor: the DUT presents a new state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge second_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (add_ready !== e.ready) begin
          failures++;
          $display("FAIL add_ready cyc=%0d got=%b exp=%b", e.cyc, add_ready, e.ready);
        end
        checks++;
        if (bcd !== e.bcd) begin
          failures++;
          $display("FAIL bcd cyc=%0d got=%h exp=%h", e.cyc, bcd, e.bcd);
        end
        checks++;
        if (expired !== e.expired) begin
          failures++;
          $display("FAIL expired cyc=%0d got=%b exp=%b", e.cyc, expired, e.expired);
        end
        checks++;
        if (low_time !== e.low) begin
          failures++;
          $display("FAIL low_time cyc=%0d got=%b exp=%b", e.cyc, low_time, e.low);
        end
        checks++;
        if (blank !== e.blank) begin
          failures++;
          $display("FAIL blank cyc=%0d got=%b exp=%b", e.cyc, blank, e.blank);
        end
      end
    end
  end

  initial begin
    int unsigned pick;
    reset = 1'b1; load_valid = 1'b0; load_sel = 1'b0; add_valid = 1'b0; add_sel = 2'd0;

    // Reset with a request pending, then countdown into the low window.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(6);
    idle(48);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(2);

    // Expire and hold, then add while expired, then load beats add.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(12);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
    idle(2);

    // Saturation via repeated +550, then a decrement from the ceiling.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    idle(2);

    // Reach 1005, count through 1000 -> 0999, then 0995 + 10 -> 1005.
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 63);
      if (pick == 0)
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else if (pick < 5)
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else if (pick < 14)
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      else
        idle(1);
    end

    @(posedge second_clk);
    #3;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/meter_bcd_timer.md
METER_BCD_TIMER -- requirements
Module: meter_bcd_timer

Interface
REQ-001 Parameter SAT_MAX, default 9999, BCD saturation ceiling for remaining time; SHALL be 1..9999.
REQ-002 Parameter LOW_THRESH, default 200, low-time warning threshold in seconds; SHALL be 1..SAT_MAX.
REQ-003 second_clk  input  1  block clock, one rising edge per elapsed second.
REQ-004 reset  input  1  reset, synchronous, active-high; clock second_clk.
REQ-005 add_valid  input  1  add request pending from the button stage.
REQ-006 add_sel  input  2  add amount code: 0=+10, 1=+180, 2=+200, 3=+550 seconds.
REQ-007 add_ready  output  1  high when an add request is accepted this cycle.
REQ-008 load_valid  input  1  preset request.
REQ-009 load_sel  input  1  preset code: 0=10 s, 1=205 s.
REQ-010 bcd  output  16  remaining time as four packed BCD digits, [15:12] thousands.
REQ-011 expired  output  1  high when bcd == 0000.
REQ-012 low_time  output  1  high when 0 < remaining < LOW_THRESH.
REQ-013 blank  output  1  display blanking phase for the downstream display driver.

Function
REQ-014 Remaining time SHALL be held only as four BCD digits; no binary copy.
REQ-015 Each cycle, priority SHALL be: reset > load > add > decrement.
REQ-016 load_valid high: next bcd = 0010 or 0205 per load_sel; pending add not accepted (add_ready=0).
REQ-017 add_valid high without load: add_ready=1 same cycle; next bcd = min(bcd + amount, SAT_MAX) in decimal; decrement skipped that cycle.
REQ-018 add_ready SHALL be combinational: add_valid & ~load_valid & ~reset.
REQ-019 No request: bcd > 0000 decrements by one with decimal borrow (e.g. 1000 -> 0999); bcd == 0000 holds.
REQ-020 Add result exceeding SAT_MAX SHALL saturate at SAT_MAX, never wrap (9900 + 550 -> 9999).
REQ-021 Digit carry/borrow SHALL ripple within one cycle; every digit SHALL stay in 0..9.
REQ-022 expired and low_time SHALL be combinational decodes of the current bcd register.
REQ-023 blank (with REQ-030): toggles every cycle while low_time=1 (period 2 s); held 1 while expired=1; 0 otherwise; phase restarts at 0 on entry to low_time.
REQ-024 Add while expired: expired deasserts next cycle; blank returns to 0 or restarts per REQ-023.

Reset
REQ-025 reset high at an edge: bcd=0000, blank=0 next cycle; add/load that cycle ignored.
REQ-026 After reset: expired=1, low_time=0, add_ready=0 while reset held.
REQ-027 Reset mid-countdown or mid-blink SHALL abort immediately with no partial update.

Configuration
REQ-028 Macro METER_BLINK_EN controls blink generation.
REQ-029 Without METER_BLINK_EN: blank tied to 0, no phase register.
REQ-030 With METER_BLINK_EN: blank behaves per REQ-023.

Structure
REQ-031 Shared package meter_pkg SHALL hold add codes/BCD amounts (0010, 0180, 0200, 0550) and preset values (0010, 0205).
REQ-032 One sub-module bcd_digit: single-digit add with carry-in/out and decrement with borrow-in/out, instantiated four times.
REQ-033 Saturation compare, priority mux and blink phase SHALL live in meter_bcd_timer.

Verification
REQ-034 Reset, load_sel=1, then 6 idle cycles -> bcd 0205, 0204 ... 0199; low_time rises at 0199; blank 0,1,0 from there.
REQ-035 bcd=0001, idle 2 cycles -> 0000 then holds 0000; expired=1, blank=1.
REQ-036 bcd=9900, add_sel=3 -> bcd=9999, add_ready=1, no decrement that cycle.
REQ-037 bcd=1000, idle -> 0999 (multi-digit borrow); bcd=0995, add_sel=0 -> 1005 (multi-digit carry).
REQ-038 load_valid and add_valid together, load_sel=0 -> bcd=0010, add_ready=0.
REQ-039 Reset asserted with bcd=0150 and blink active -> next cycle bcd=0000, blank=0; repeat with METER_BLINK_EN undefined -> blank always 0.
